// File: rtl/bp_cce_pkg.sv
// Shared encodings for the CCE config-link responder: address regions,
// register offsets and the responder FSM state type.
package bp_cce_pkg;

  localparam logic [1:0]  cfg_region_inst_lp = 2'b00;
  localparam logic [1:0]  cfg_region_reg_lp  = 2'b01;

  localparam logic [12:0] cfg_reg_mode_off_lp   = 13'd0;
  localparam logic [12:0] cfg_reg_status_off_lp = 13'd1;

  typedef enum logic [1:0] {
    e_cfg_idle    = 2'b00,
    e_cfg_rd_wait = 2'b01,
    e_cfg_resp    = 2'b10
  } cce_cfg_state_e;

endpackage

// File: rtl/bp_cce_cfg_responder.sv
// Config-link slave for the CCE: stages split instruction writes into the
// external instruction RAM, serves mode/status registers, one read outstanding.
module bp_cce_cfg_responder
  import bp_cce_pkg::*;
#(
  parameter int cfg_link_addr_width_p = 16,
  parameter int cfg_link_data_width_p = 32,
  parameter int inst_width_p          = 48,
  parameter int inst_ram_addr_width_p = 8
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              freeze_i,
  input  logic [cfg_link_addr_width_p-2:0]  config_addr_i,
  input  logic [cfg_link_data_width_p-1:0]  config_data_i,
  input  logic                              config_v_i,
  input  logic                              config_w_i,
  output logic                              config_ready_o,
  output logic [cfg_link_data_width_p-1:0]  config_data_o,
  output logic                              config_v_o,
  input  logic                              config_ready_i,
  output logic                              inst_ram_v_o,
  output logic                              inst_ram_w_o,
  output logic [inst_ram_addr_width_p-1:0]  inst_ram_addr_o,
  output logic [inst_width_p-1:0]           inst_ram_data_o,
  input  logic [inst_width_p-1:0]           inst_ram_data_i,
  output logic [1:0]                        cce_mode_o
);

  localparam int hi_w_lp = inst_width_p - 32;
  typedef logic [cfg_link_data_width_p-1:0] cfg_data_t;

  cce_cfg_state_e                   state;
  logic [31:0]                      stage_data;
  logic [inst_ram_addr_width_p-1:0] stage_idx;
  logic                             stage_v;
  logic                             err_sticky;
  logic [15:0]                      writes_committed;
  logic                             rd_hi;
  cfg_data_t                        resp_data;

  logic [1:0]                       region;
  logic [12:0]                      offset;
  logic [inst_ram_addr_width_p-1:0] idx;
  logic                             sel_hi, accept, is_inst, is_reg, ram_ok;
  logic                             stage_hit;
  logic [31:0]                      lo_data;
  cfg_data_t                        reg_rdata;

  assign region    = config_addr_i[14:13];
  assign offset    = config_addr_i[12:0];
  assign idx       = config_addr_i[inst_ram_addr_width_p:1];
  assign sel_hi    = config_addr_i[0];
  assign is_inst   = (region == cfg_region_inst_lp);
  assign is_reg    = (region == cfg_region_reg_lp);

  assign config_ready_o = (state == e_cfg_idle) & ~reset_i;
  assign accept         = config_v_i & config_ready_o;
  assign ram_ok         = accept & is_inst & freeze_i;

  assign stage_hit = stage_v & (stage_idx == idx);
  assign lo_data   = stage_hit ? stage_data : 32'd0;

  // Lo-half writes only stage; the RAM sees hi-half writes and all reads.
  assign inst_ram_v_o    = ram_ok & (~config_w_i | sel_hi);
  assign inst_ram_w_o    = ram_ok & config_w_i & sel_hi;
  assign inst_ram_addr_o = idx;
  assign inst_ram_data_o = {config_data_i[hi_w_lp-1:0], lo_data};

  assign config_v_o    = (state == e_cfg_resp) & ~reset_i;
  assign config_data_o = resp_data;

  always_comb begin
    reg_rdata = '0;
    if (is_reg && offset == cfg_reg_mode_off_lp)
      reg_rdata = cfg_data_t'(cce_mode_o);
    else if (is_reg && offset == cfg_reg_status_off_lp)
      reg_rdata = cfg_data_t'({err_sticky, 15'b0, writes_committed});
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= e_cfg_idle;
      resp_data        <= '0;
      cce_mode_o       <= '0;
      stage_v          <= 1'b0;
      stage_data       <= '0;
      stage_idx        <= '0;
      err_sticky       <= 1'b0;
      writes_committed <= '0;
      rd_hi            <= 1'b0;
    end else begin
      case (state)
        e_cfg_idle: if (accept) begin
          if (config_w_i) begin
            if (is_inst) begin
              if (!freeze_i) begin
                err_sticky <= 1'b1;
              end else if (!sel_hi) begin
                stage_data <= config_data_i[31:0];
                stage_idx  <= idx;
                stage_v    <= 1'b1;
              end else begin
                if (!stage_hit) err_sticky <= 1'b1;
                stage_v          <= 1'b0;
                writes_committed <= writes_committed + 16'd1;
              end
            end else if (is_reg && offset == cfg_reg_mode_off_lp) begin
              cce_mode_o <= config_data_i[1:0];
            end
          end else if (is_inst && freeze_i) begin
            rd_hi <= sel_hi;
            state <= e_cfg_rd_wait;
          end else begin
            // Unfrozen instruction reads still answer, with zero data.
            if (is_inst) err_sticky <= 1'b1;
            resp_data <= reg_rdata;
            state     <= e_cfg_resp;
          end
        end
        e_cfg_rd_wait: begin
          resp_data <= rd_hi ? cfg_data_t'(inst_ram_data_i[inst_width_p-1:32])
                             : cfg_data_t'(inst_ram_data_i[31:0]);
          state     <= e_cfg_resp;
        end
        e_cfg_resp: if (config_ready_i) state <= e_cfg_idle;
        default: state <= e_cfg_idle;
      endcase
    end
  end

endmodule
